// File: rtl/awmc_pkg.sv
// Shared AWMC definitions: default front-end timing and the controller stage encodings
// used by every stage downstream of the input conditioner.
package awmc_pkg;

    localparam int AWMC_TICK_DIV  = 50;
    localparam int AWMC_DB_CYCLES = 4;

    typedef enum logic [2:0] {
        AWMC_FILL  = 3'b000,
        AWMC_WASH  = 3'b001,
        AWMC_RINSE = 3'b010,
        AWMC_SPIN  = 3'b011,
        AWMC_STOP  = 3'b100,
        AWMC_IDLE  = 3'b111
    } awmc_stage_t;

endpackage

// File: rtl/awmc_debounce.sv
// Two-flop synchronizer followed by a consecutive-difference debouncer for one
// asynchronous panel input. The stable level only follows after DB_CYCLES agreeing cycles.
module awmc_debounce
    import awmc_pkg::*;
#(
    parameter  int DB_CYCLES = AWMC_DB_CYCLES,
    localparam int DW        = $clog2(DB_CYCLES + 1)
) (
    input  logic c_in,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    always_ff @(posedge c_in or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle of agreement with the stable value restarts the count.
    always_ff @(posedge c_in or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == DW'(DB_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= sync2;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/awmc_input_conditioner.sv
// Panel front-end for the AWMC controller: debounced lid/pause levels, a start request
// stretched to the next controller tick, and the slow tick used as the controller's enable.
module awmc_input_conditioner
    import awmc_pkg::*;
#(
    parameter  int TICK_DIV  = AWMC_TICK_DIV,
    parameter  int DB_CYCLES = AWMC_DB_CYCLES,
    localparam int TW        = $clog2(TICK_DIV)
) (
    input  logic c_in,
    input  logic reset,
    input  logic start_btn,
    input  logic pause_btn,
    input  logic lid_raw,
    output logic tick,
    output logic start,
    output logic pause,
    output logic lid
);

    logic [TW-1:0] tick_cnt;
    logic          stable_start;
    logic          stable_pause;
    logic          stable_lid;
    logic          prev_stable_start;
    logic          start_latch;
    logic          rise;

    awmc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .c_in   (c_in),
        .reset  (reset),
        .raw    (start_btn),
        .stable (stable_start)
    );

    awmc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .c_in   (c_in),
        .reset  (reset),
        .raw    (pause_btn),
        .stable (stable_pause)
    );

    awmc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lid (
        .c_in   (c_in),
        .reset  (reset),
        .raw    (lid_raw),
        .stable (stable_lid)
    );

    // tick is registered, so it lands one cycle after the counter's last value.
    always_ff @(posedge c_in or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TW'(TICK_DIV - 1));
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    assign rise = stable_start & ~prev_stable_start;

    // Set has priority over the tick clear so a press arriving on a tick cycle is
    // still delivered on the following tick.
    always_ff @(posedge c_in or negedge reset) begin
        if (!reset) begin
            prev_stable_start <= 1'b0;
            start_latch       <= 1'b0;
        end else begin
            prev_stable_start <= stable_start;
            if (rise && !stable_pause) begin
                start_latch <= 1'b1;
            end else if (tick) begin
                start_latch <= 1'b0;
            end
        end
    end

    assign start = start_latch;
    assign pause = stable_pause;
    assign lid   = stable_lid;

endmodule

// File: doc/awmc_input_conditioner.md
Name: awmc_input_conditioner

Overview:
- Front-end stage directly upstream of the AWMC controller. It conditions the raw panel inputs (start button, pause button, lid switch) and generates the controller's slow step-enable tick.
- It outputs a synchronized, debounced lid level and pause level, plus a start request. The start request is stretched so the controller samples it on its next tick cycle.
- All logic runs on the fast clock c_in. The tick output drives the controller's clk enable input.

Parameters:
- TICK_DIV, 50, c_in cycles per tick period; must be ≥2.
- DB_CYCLES, 4, consecutive c_in cycles a synchronized input must differ from its stable value before the stable value updates; must be ≥1.
- TW, $clog2(TICK_DIV), tick counter width (derived).
- DW, $clog2(DB_CYCLES+1), debounce counter width (derived).

Ports:
- c_in, input, 1, system clock; all flops are rising-edge.
- reset, input, 1, asynchronous active-low reset; 0 resets every flop immediately.
- start_btn, input, 1, raw start push-button, asynchronous.
- pause_btn, input, 1, raw pause push-button, asynchronous.
- lid_raw, input, 1, raw lid switch (1 = open), asynchronous.
- tick, output, 1, one-c_in-cycle pulse every TICK_DIV cycles; feeds controller clk.
- start, output, 1, stretched start request; feeds controller start.
- pause, output, 1, debounced pause level; feeds controller pause.
- lid, output, 1, debounced lid level; feeds controller lid.

Behaviour:
- Reset (reset=0, asynchronous):
  - tick_cnt=0.
  - All synchronizer flops, stable values and debounce counters = 0.
  - start_latch=0, previous-stable-start=0.
  - Outputs tick, start, pause and lid all 0.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered: it is 1 during the cycle after tick_cnt==TICK_DIV-1.
  - Exactly one tick per TICK_DIV cycles; the first tick occurs TICK_DIV cycles after reset release.
- Synchronizer: each raw input passes through 2 flops (sync1→sync2) before debounce.
- Debounce (per input, identical logic):
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES, stable <= sync2 and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles leaves stable unchanged.
  - Latency from a clean raw edge to the stable change is 2+DB_CYCLES c_in cycles.
- pause = stable_pause and lid = stable_lid, driven directly from registers with no extra delay.
- Start stretching:
  - rise = stable_start & ~prev_stable_start, where prev_stable_start is registered every cycle.
  - rise with stable_pause==1 is ignored; no start while paused.
  - start_latch sets on rise and clears on any cycle where tick==1.
  - If set and clear coincide, set wins and the request is held until the next tick.
  - start = start_latch. The controller therefore sees start=1 on exactly one tick cycle per accepted press.
- Multiple rises before a tick merge into one request; no counting or queueing.
- Holding start_btn produces one request only; a new request needs release (stable 0) and a new press.
- Reset mid-operation discards any pending start and restarts tick phase from 0.
- lid and pause carry no interlock logic here; the controller owns policy.
- No combinational path from any input to any output.

Decomposition:
- awmc_pkg holds defaults AWMC_TICK_DIV=50 and AWMC_DB_CYCLES=4. The controller's stage encodings (IDLE=3'b111, FILL=000, WASH=001, RINSE=010, SPIN=011, STOP=100) move there so that downstream stages share them.
- One sub-module, awmc_debounce (parameter DB_CYCLES; ports c_in, reset, raw, stable). It contains the 2-flop synchronizer plus the counter and is instantiated 3×.
- Tick generator and start stretcher stay inline in the top.

Test Plan:
- Reset release, inputs 0, TICK_DIV=50 → tick pulses on cycles 50, 100, 150, each 1 cycle wide; start, pause and lid remain 0.
- lid_raw 0→1 held, DB_CYCLES=4 → lid rises exactly 6 cycles after the raw edge. A 3-cycle lid_raw glitch → lid never changes.
- start_btn press held 200 cycles → start rises 7 cycles after the edge (2 sync + 4 debounce + 1 edge register), stays 1 through the next tick cycle, then clears. Exactly one tick cycle sees start=1.
- Debounced start rise landing on the same cycle as tick → start stays 1 until the following tick, 50 cycles later, then clears.
- pause_btn held high, then start_btn pressed → pause=1, start never asserts. Release pause, press again → start asserts normally.
- Start pending, reset pulsed low mid-period → start=0 and tick=0 immediately. After release, the first tick comes 50 cycles later with no stale start.
